regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NUM_REGS, default 16, number of architectural registers in the register file served.
REQ-002 Parameter FIFO_DEPTH, default 2, entries in the multi-cycle-unit (MU) write buffer.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 wb_valid  in  1  pipeline writeback write request; cannot be back-pressured.
REQ-006 wb_rd  in  5  writeback destination register.
REQ-007 wb_data  in  32  writeback data.
REQ-008 mu_issue  in  1  MU has started an operation targeting mu_issue_rd.
REQ-009 mu_issue_rd  in  5  destination of the issued MU operation.
REQ-010 mu_valid  in  1  MU result ready to write.
REQ-011 mu_ready  out  1  arbiter accepts MU result this cycle (mu_valid & mu_ready = transfer).
REQ-012 mu_rd  in  5  MU result destination.
REQ-013 mu_data  in  32  MU result data.
REQ-014 rs, rt  in  5 each  source registers of the instruction in decode.
REQ-015 stall  out  1  decode must stall: rs or rt has a pending MU write.
REQ-016 rf_reg_write, rf_rd, rf_write_data  out  1/5/32  register file write port (file samples on falling clk edge).
REQ-017 err  out  1  sticky protocol-error flag.

Function
REQ-018 Arbitration each cycle: grant WB if wb_valid and wb_rd < NUM_REGS; else grant FIFO head if FIFO non-empty; else grant the MU input directly if mu_valid (bypass); else no write.
REQ-019 The granted write SHALL appear on rf_* outputs registered, one cycle after sampling, so it is stable at the following falling edge; rf_reg_write=0 when no grant.
REQ-020 mu_ready SHALL equal (FIFO count < FIFO_DEPTH), combinational from registered count only.
REQ-021 An accepted MU result not granted in the same cycle SHALL be pushed into the FIFO; FIFO order is strict FIFO.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; a full FIFO never receives a push (mu_ready=0).
REQ-023 Any request with rd >= NUM_REGS SHALL be discarded (no write), sets err, and for MU entries still pops/clears normally.
REQ-024 Scoreboard: NUM_REGS-bit pending vector; mu_issue sets pending[mu_issue_rd]; issuing an MU write to rf_* clears pending[rd].
REQ-025 Set and clear of the same bit in one cycle: set wins.
REQ-026 mu_issue to a register already pending SHALL set err; pending stays set.
REQ-027 stall = pending[rs] | pending[rt], combinational; indices >= NUM_REGS read as 0.
REQ-028 WB writes never touch the scoreboard; MU may starve while wb_valid is continuously high (accepted by design).
REQ-029 Register 0 is an ordinary writable register (no hardwired zero).

Reset
REQ-030 While rst_n=0: rf_reg_write=0, rf_rd=0, rf_write_data=0, FIFO count=0, pending=0, err=0; mu_ready reads 1 once rst_n releases.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents and pending bits immediately, with no write issued on the next falling edge.

Structure
REQ-032 Shared package rf_ctrl_pkg holds NUM_REGS, FIFO_DEPTH defaults, REG_ADDR_W=5, DATA_W=32 and the write-request record (rd, data).
REQ-033 FIFO implemented as one sub-module rf_wr_fifo (count, head, push/pop, async active-low reset); arbitration and scoreboard stay in the top.

Verification
REQ-034 Idle, mu_issue rd=3, then mu_valid rd=3 data=0x1234 -> stall high for rs=3 until rf write rd=3 data 0x1234 one cycle after mu_valid; stall low next cycle.
REQ-035 wb_valid rd=5 data=0xA0 and mu_valid rd=7 data=0xBEEF same cycle -> rf write rd=5 first, rd=7 next cycle; FIFO count peaks at 1.
REQ-036 wb_valid held 4 cycles while MU offers 3 results -> mu_ready drops after 2 accepted; after WB drops, writes drain in MU order, mu_ready returns to 1.
REQ-037 wb_valid with wb_rd=20 -> no rf write, err=1 and stays 1 until reset.
REQ-038 FIFO holds 2 entries and pending bits set, pulse rst_n low -> rf_reg_write=0, stall=0, mu_ready=1 after release, no stale writes.
REQ-039 mu_issue rd=9 in the same cycle the FIFO entry for rd=9 is written -> pending[9] remains 1, stall for rs=9 stays high.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write path: default sizing, field widths,
// the write-request record carried through the MU buffer, and an address range helper.
package rf_ctrl_pkg;

  localparam int unsigned NUM_REGS_DEF   = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 2;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned DATA_W         = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wr_req_t;

  // True when rd names a register that actually exists in the file.
  function automatic logic rd_in_range(input logic [REG_ADDR_W-1:0] rd,
                                       input int unsigned num_regs);
    return 32'(rd) < num_regs;
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small FIFO buffering multi-cycle-unit results that lost arbitration.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (drops all contents)
//   push_i         write push_req_i at the tail (caller never pushes when full)
//   push_req_i     entry to store
//   pop_i          discard the head entry (caller never pops when empty)
//   head_o         oldest entry, valid while count_o != 0
//   count_o        number of stored entries
module rf_wr_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  wr_req_t         push_req_i,
  input  logic            pop_i,
  output wr_req_t         head_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_req_t         mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count_q says they are live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_req_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single-port register-file write arbiter between the pipeline writeback (never stalls)
// and a multi-cycle unit (buffered through rf_wr_fifo), plus a pending-write scoreboard
// that stalls decode on operands still owed by the MU.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data           writeback request (highest priority)
//   mu_issue/mu_issue_rd             MU operation started: mark rd pending
//   mu_valid/mu_ready/mu_rd/mu_data  MU result handshake
//   rs, rt / stall                   decode operands / stall on pending operand
//   rf_reg_write/rf_rd/rf_write_data registered write port to the file
//   err                              sticky protocol error
module regfile_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  mu_issue,
  input  logic [REG_ADDR_W-1:0] mu_issue_rd,
  input  logic                  mu_valid,
  output logic                  mu_ready,
  input  logic [REG_ADDR_W-1:0] mu_rd,
  input  logic [DATA_W-1:0]     mu_data,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  stall,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0]     rf_write_data,
  output logic                  err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [CntW-1:0]       fifo_count;
  wr_req_t               fifo_head;
  logic                  fifo_push, fifo_pop;
  logic                  wb_ok, grant_fifo, grant_byp, mu_grant, mu_sel_ok, clr_hit, issue_err;
  wr_req_t               mu_sel;
  logic [31:0]           pend_ext;

  logic                  rf_reg_write_q, rf_reg_write_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]     rf_write_data_q, rf_write_data_d;
  logic                  err_q, err_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  rf_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (fifo_push),
    .push_req_i ({mu_rd, mu_data}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

  assign mu_ready = 32'(fifo_count) < FIFO_DEPTH;

  // Arbitration: valid WB, then buffered MU head, then MU input bypass.
  always_comb begin
    wb_ok      = wb_valid & rd_in_range(wb_rd, NUM_REGS);
    grant_fifo = !wb_ok && (fifo_count != '0);
    grant_byp  = !wb_ok && (fifo_count == '0) && mu_valid;
    mu_grant   = grant_fifo | grant_byp;
    mu_sel     = grant_fifo ? fifo_head : wr_req_t'({mu_rd, mu_data});
    mu_sel_ok  = rd_in_range(mu_sel.rd, NUM_REGS);
    fifo_pop   = grant_fifo;
    fifo_push  = mu_valid & mu_ready & !grant_byp;

    rf_reg_write_d  = wb_ok | (mu_grant & mu_sel_ok);
    rf_rd_d         = rf_rd_q;
    rf_write_data_d = rf_write_data_q;
    if (wb_ok) begin
      rf_rd_d         = wb_rd;
      rf_write_data_d = wb_data;
    end else if (mu_grant && mu_sel_ok) begin
      rf_rd_d         = mu_sel.rd;
      rf_write_data_d = mu_sel.data;
    end
  end

  // Scoreboard. Clears are applied first so a same-cycle issue to the same rd wins.
  always_comb begin
    pend_ext  = 32'(pending_q);
    pending_d = pending_q;
    issue_err = 1'b0;
    clr_hit   = mu_grant & mu_sel_ok & (mu_sel.rd == mu_issue_rd);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (mu_grant && mu_sel_ok && (mu_sel.rd == REG_ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    if (mu_issue) begin
      if (!rd_in_range(mu_issue_rd, NUM_REGS)) begin
        issue_err = 1'b1;
      end else begin
        // Re-issue is legal only when the previous owner retires in this same cycle.
        issue_err = pend_ext[mu_issue_rd] & !clr_hit;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (mu_issue_rd == REG_ADDR_W'(i)) begin
            pending_d[i] = 1'b1;
          end
        end
      end
    end
    err_d = err_q | issue_err | (wb_valid & !wb_ok) | (mu_grant & !mu_sel_ok);
  end

  assign stall = pend_ext[rs] | pend_ext[rt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_reg_write_q  <= 1'b0;
      rf_rd_q         <= '0;
      rf_write_data_q <= '0;
      err_q           <= 1'b0;
      pending_q       <= '0;
    end else begin
      rf_reg_write_q  <= rf_reg_write_d;
      rf_rd_q         <= rf_rd_d;
      rf_write_data_q <= rf_write_data_d;
      err_q           <= err_d;
      pending_q       <= pending_d;
    end
  end

  assign rf_reg_write  = rf_reg_write_q;
  assign rf_rd         = rf_rd_q;
  assign rf_write_data = rf_write_data_q;
  assign err           = err_q;

endmodule
